vga_sync_receiver: RTL
======================

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 Parameter H_TOTAL, 800: pixels per line, sync edge to sync edge.
REQ-002 Parameter V_TOTAL, 525: lines per frame.
REQ-003 Parameter H_VISIBLE, 640; V_VISIBLE, 480: active pixels per line and active lines per frame.
REQ-004 Parameter H_START, 144; V_START, 35: sync plus back porch, counted from the sync falling edge to the first active pixel and the first active line.
REQ-005 i_clk  in  1  pixel clock; the block SHALL use one clock only.
REQ-006 i_rst_n  in  1  asynchronous, active-low reset.
REQ-007 i_hsync, i_vsync  in  1 each  active-low syncs, synchronous to i_clk.
REQ-008 i_red_video, i_grn_video, i_blu_video  in  3 each  pixel colour.
REQ-009 o_hpos, o_vpos  out  10 each  recovered active pixel position.
REQ-010 o_visible  out  1  the recovered position is inside the active area.
REQ-011 o_locked  out  1  timing matches the parameters.
REQ-012 o_frame_strobe  out  1  one-cycle pulse on each vsync falling edge.
REQ-013 o_line_len, o_frame_lines  out  10 each  last measured line length and last measured frame length.
REQ-014 o_frame_sum  out  16  checksum of the previous frame.
REQ-015 o_sync_error  out  1  one-cycle pulse when loss of lock is detected.

Function
REQ-016 Falling edges SHALL be detected against a one-cycle registered copy of each sync input.
REQ-017 Internal column counter hc SHALL be 0 for the first low i_hsync sample and SHALL increment by 1 on every later sample.
- hc SHALL saturate at 1023.
REQ-018 Internal line counter vc SHALL increment on each hsync edge and SHALL clear to 0 on a vsync edge.
- A vsync edge SHALL take priority when both edges occur in the same cycle.
REQ-019 On each hsync edge, o_line_len SHALL load the length of the line just ended (hc+1).
REQ-020 On each vsync edge, o_frame_lines SHALL load the length of the frame just ended (vc+1, counting the coincident hsync edge).
REQ-021 Output timing:
- o_hpos SHALL equal hc-H_START and o_vpos SHALL equal vc-V_START.
- o_visible SHALL be 1 iff H_START<=hc<H_START+H_VISIBLE, V_START<=vc<V_START+V_VISIBLE, and o_locked=1.
- All three outputs SHALL be registered, with 1-cycle latency from the pixel sample.
- o_hpos and o_vpos SHALL be 0 whenever o_visible=0.
REQ-022 State machine SEARCH, ALIGN, LOCKED:
- SEARCH->ALIGN on a vsync edge.
- ALIGN->LOCKED on the next vsync edge, if every line in the frame measured H_TOTAL and the frame measured V_TOTAL.
- ALIGN->SEARCH otherwise.
REQ-023 In LOCKED, any of the following SHALL pulse o_sync_error and SHALL force SEARCH:
- a line length other than H_TOTAL;
- a frame length other than V_TOTAL;
- hc reaching 1023.
REQ-024 o_locked SHALL be 1 iff the state is LOCKED, registered.
REQ-025 The accumulator SHALL add {red,grn,blu} (9 bits, red in the MSBs), modulo 2^16, for each sample where the registered visible condition holds.
REQ-026 On a vsync edge, o_frame_sum SHALL load the accumulator value (including any final pixel) and the accumulator SHALL clear.
- o_frame_strobe SHALL pulse in the same cycle.
- o_frame_sum is meaningful only when o_locked=1.
REQ-027 o_frame_strobe SHALL pulse in every state.

Reset
REQ-028 While i_rst_n=0, the block SHALL hold state SEARCH with hc=vc=0, the accumulator at 0, and all outputs at 0.
REQ-029 Assertion of i_rst_n mid-frame SHALL immediately abandon the current frame.
- After reset releases, the block SHALL need two vsync edges before o_locked=1.

Structure
REQ-030 A shared package SHALL hold:
- the state enumeration;
- the default 640x480 timing constants, shared with the sync generator.
REQ-031 The block SHALL instantiate one sub-module, sync_edge_detect, once per sync input.

Verification
REQ-032 Drive 640x480 timing with blue=7, red=grn=0 -> o_locked=1 one cycle after the second vsync edge; the next-frame o_frame_sum=16'hD000, o_line_len=800, o_frame_lines=525.
REQ-033 After lock, shorten one line to 799 -> o_line_len=799; o_sync_error pulses once; o_locked=0; relock after two further good vsync edges.
REQ-034 Hold i_hsync high for 1100 cycles while locked -> o_sync_error at hc=1023; state SEARCH.
REQ-035 Check pixel alignment: input sample at hc=144, vc=35 -> next cycle o_visible=1, o_hpos=0, o_vpos=0. Input sample at hc=783, vc=514 -> o_hpos=639, o_vpos=479; the following sample -> o_visible=0.
REQ-036 Assert i_rst_n=0 mid-frame for 3 cycles -> all outputs 0; no o_frame_strobe until the next vsync edge; o_locked stays 0 through the first full frame.
REQ-037 Apply coincident hsync and vsync edges -> vc=0 (not 1) in the following cycle.

Source files
------------

// File: rtl/vga_sync_receiver_pkg.sv
// Shared types and default 640x480 timing for the VGA sync receiver and generator.
package vga_sync_receiver_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_ALIGN,
        ST_LOCKED
    } rx_state_e;

    // Column/line counters are 10 bits and stick at their maximum.
    localparam int                CNT_W   = 10;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    // Default 640x480@60 timing, measured from the sync falling edge.
    localparam int VGA_H_TOTAL   = 800;
    localparam int VGA_V_TOTAL   = 525;
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_H_START   = 144;
    localparam int VGA_V_START   = 35;

    // Saturating increment shared by both counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_sync_receiver_if.sv
// Video-in / recovered-timing bundle of the VGA sync receiver.
interface vga_sync_receiver_if;
    import vga_sync_receiver_pkg::*;

    logic             i_hsync;
    logic             i_vsync;
    logic [2:0]       i_red_video;
    logic [2:0]       i_grn_video;
    logic [2:0]       i_blu_video;
    logic [CNT_W-1:0] o_hpos;
    logic [CNT_W-1:0] o_vpos;
    logic             o_visible;
    logic             o_locked;
    logic             o_frame_strobe;
    logic [CNT_W-1:0] o_line_len;
    logic [CNT_W-1:0] o_frame_lines;
    logic [15:0]      o_frame_sum;
    logic             o_sync_error;

    // Video source side
    modport master (
        output i_hsync, i_vsync, i_red_video, i_grn_video, i_blu_video,
        input  o_hpos, o_vpos, o_visible, o_locked, o_frame_strobe,
               o_line_len, o_frame_lines, o_frame_sum, o_sync_error
    );

    // Receiver side
    modport slave (
        input  i_hsync, i_vsync, i_red_video, i_grn_video, i_blu_video,
        output o_hpos, o_vpos, o_visible, o_locked, o_frame_strobe,
               o_line_len, o_frame_lines, o_frame_sum, o_sync_error
    );

endinterface

// File: rtl/sync_edge_detect.sv
// Falling-edge detector for one active-low sync input.
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sync,
    output logic o_fall
);

    logic sync_d, sync_q;

    // Previous sample of the sync line; reset low so a sync already low at release is not an edge.
    always_comb sync_d = i_sync;

    // Registered copy of the sync input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_q <= 1'b0;
        else          sync_q <= sync_d;
    end

    assign o_fall = sync_q & ~i_sync;

endmodule

// File: rtl/vga_sync_receiver.sv
// Recovers pixel position from VGA syncs, tracks lock and checksums visible pixels per frame.
module vga_sync_receiver
    import vga_sync_receiver_pkg::*;
#(
    parameter int H_TOTAL   = VGA_H_TOTAL,
    parameter int V_TOTAL   = VGA_V_TOTAL,
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int H_START   = VGA_H_START,
    parameter int V_START   = VGA_V_START
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    vga_sync_receiver_if.slave  bus
);

    localparam logic [CNT_W-1:0] H_TOT_C   = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] V_TOT_C   = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_START + H_VISIBLE);
    localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_START + V_VISIBLE);

    // bit 0 = hsync, bit 1 = vsync
    logic [1:0] sync_in, sync_fall;
    logic       hs_edge, vs_edge;

    assign sync_in = {bus.i_vsync, bus.i_hsync};

    for (genvar g = 0; g < 2; g++) begin : g_edge
        sync_edge_detect u_edge (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_sync  (sync_in[g]),
            .o_fall  (sync_fall[g])
        );
    end

    assign hs_edge = sync_fall[0];
    assign vs_edge = sync_fall[1];

    rx_state_e        state_d, state_q;
    logic [CNT_W-1:0] hc_d, hc_q, vc_d, vc_q;
    logic [CNT_W-1:0] hpos_d, hpos_q, vpos_d, vpos_q;
    logic [CNT_W-1:0] line_len_d, line_len_q, frame_lines_d, frame_lines_q;
    logic             vis_d, vis_q, locked_d, locked_q;
    logic             strobe_d, strobe_q, sync_err_d, sync_err_q;
    logic             line_bad_d, line_bad_q;
    logic [8:0]       pix_d, pix_q;
    logic [15:0]      acc_d, acc_q, sum_d, sum_q, acc_add;

    // Measurements of the line/frame that ends on this sample's edges.
    logic [CNT_W-1:0] cur_len, cur_lines;
    logic             len_bad, lines_bad, hc_sat, frame_ok;

    assign cur_len   = sat_inc(hc_q);
    assign cur_lines = sat_inc(vc_q);
    assign len_bad   = hs_edge && (cur_len != H_TOT_C);
    assign lines_bad = vs_edge && (cur_lines != V_TOT_C);
    assign hc_sat    = (hc_d == CNT_MAX);
    // The line closed by a coincident hsync edge still belongs to the frame being judged.
    assign frame_ok  = !line_bad_q && !len_bad && !hc_sat && (cur_lines == V_TOT_C);

    // Counters, measurements, position outputs and frame checksum.
    always_comb begin
        hc_d          = hs_edge ? '0 : sat_inc(hc_q);
        vc_d          = vc_q;
        if (vs_edge)      vc_d = '0;
        else if (hs_edge) vc_d = sat_inc(vc_q);
        line_len_d    = hs_edge ? cur_len : line_len_q;
        line_bad_d    = vs_edge ? 1'b0 : (line_bad_q | len_bad | hc_sat);

        vis_d         = (hc_d >= H_START_C) && (hc_d < H_END_C) &&
                        (vc_d >= V_START_C) && (vc_d < V_END_C) && locked_q;
        hpos_d        = vis_d ? hc_d - H_START_C : '0;
        vpos_d        = vis_d ? vc_d - V_START_C : '0;
        pix_d         = {bus.i_red_video, bus.i_grn_video, bus.i_blu_video};

        // Pixel and its visible flag are one sample behind, so the edge cycle closes out the last pixel.
        acc_add       = acc_q + (vis_q ? {7'd0, pix_q} : 16'd0);
        acc_d         = acc_add;
        sum_d         = sum_q;
        frame_lines_d = frame_lines_q;
        strobe_d      = 1'b0;
        if (vs_edge) begin
            acc_d         = '0;
            sum_d         = acc_add;
            frame_lines_d = cur_lines;
            strobe_d      = 1'b1;
        end
    end

    // Lock tracking: two consecutive clean vsync edges to lock, any timing fault drops it.
    always_comb begin
        state_d    = state_q;
        sync_err_d = 1'b0;
        case (state_q)
            ST_SEARCH: if (vs_edge) state_d = ST_ALIGN;
            ST_ALIGN:  if (vs_edge) state_d = frame_ok ? ST_LOCKED : ST_SEARCH;
            ST_LOCKED: if (len_bad || lines_bad || hc_sat) begin
                state_d    = ST_SEARCH;
                sync_err_d = 1'b1;
            end
            default:   state_d = ST_SEARCH;
        endcase
        locked_d = (state_d == ST_LOCKED);
    end

    // All state and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_SEARCH;
            hc_q          <= '0;
            vc_q          <= '0;
            hpos_q        <= '0;
            vpos_q        <= '0;
            vis_q         <= 1'b0;
            locked_q      <= 1'b0;
            strobe_q      <= 1'b0;
            sync_err_q    <= 1'b0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            line_bad_q    <= 1'b0;
            pix_q         <= '0;
            acc_q         <= '0;
            sum_q         <= '0;
        end else begin
            state_q       <= state_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            vis_q         <= vis_d;
            locked_q      <= locked_d;
            strobe_q      <= strobe_d;
            sync_err_q    <= sync_err_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            line_bad_q    <= line_bad_d;
            pix_q         <= pix_d;
            acc_q         <= acc_d;
            sum_q         <= sum_d;
        end
    end

    assign bus.o_hpos         = hpos_q;
    assign bus.o_vpos         = vpos_q;
    assign bus.o_visible      = vis_q;
    assign bus.o_locked       = locked_q;
    assign bus.o_frame_strobe = strobe_q;
    assign bus.o_line_len     = line_len_q;
    assign bus.o_frame_lines  = frame_lines_q;
    assign bus.o_frame_sum    = sum_q;
    assign bus.o_sync_error   = sync_err_q;

endmodule
